pwm_demodulator: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/duty_divider.sv | 73 +++++++
 rtl/pwm_demodulator.sv | 143 ++++++++++++++
 tb/tb_pwm_demodulator.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths and FSM encoding for the PWM modulator/demodulator pair
package pwm_pkg;

  localparam int PWM_N_BITS   = 8;
  localparam int PWM_CNT_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/duty_divider.sv
// rtl/duty_divider.sv - restoring divider producing floor(dividend*2^N_bits/divisor)
// One quotient bit per cycle; done is raised for one cycle after the last iteration.
module duty_divider
  import pwm_pkg::*;
#(
  parameter int N_bits   = PWM_N_BITS,
  parameter int CNT_BITS = PWM_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_BITS-1:0] dividend,
  input  logic [CNT_BITS-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [N_bits-1:0]   quotient
);

  localparam int CW = $clog2(N_bits + 1);
  localparam int RW = CNT_BITS + 1;

  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic [CNT_BITS-1:0] dsr_q, dsr_d;
  logic [N_bits-1:0]   quo_q, quo_d;
  logic [RW:0]         rem_sh;
  logic                take;

  assign done     = busy_q && (cnt_q == CW'(N_bits));
  assign busy     = busy_q;
  assign quotient = quo_q;

  always_comb begin
    rem_sh = {rem_q, 1'b0};
    take   = rem_sh >= {2'b00, dsr_q};
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    quo_d  = quo_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = {1'b0, dividend};
      dsr_d  = divisor;
      quo_d  = '0;
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      rem_d = take ? RW'(rem_sh - {2'b00, dsr_q}) : RW'(rem_sh);
      quo_d = {quo_q[N_bits-2:0], take};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      quo_q  <= quo_d;
    end
  end

endmodule

// File: rtl/pwm_demodulator.sv
// rtl/pwm_demodulator.sv - recovers period, high time and duty code from an external PWM pin
// Measures between synchronised rising edges, then normalises high/period with duty_divider.
module pwm_demodulator
  import pwm_pkg::*;
#(
  parameter int N_bits      = PWM_N_BITS,
  parameter int CNT_BITS    = PWM_CNT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [N_bits-1:0]   duty,
  output logic [CNT_BITS-1:0] period,
  output logic [CNT_BITS-1:0] high_time,
  output logic                valid,
  output logic                timeout
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   s, rise;
  logic [CNT_BITS-1:0]    per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_BITS-1:0]    period_q, period_d, high_time_q, high_time_d;
  logic [N_bits-1:0]      duty_q, duty_d;
  logic                   valid_q, valid_d, timeout_q, timeout_d, stale_q, stale_d;
  pwm_state_e             state_q, state_d;
  logic                   div_start, div_busy, div_done;
  logic [N_bits-1:0]      div_quotient;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_dly_q;
  assign duty      = duty_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_dly_d   = s;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = CNT_BITS'(1);
      hi_cnt_d  = CNT_BITS'(1);
    end else begin
      if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_BITS'(1);
      if (s && hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + CNT_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rise) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (rise) state_d = ST_DIVIDE;
        else if (per_cnt_q == CNT_MAX) state_d = ST_IDLE;
      end
      ST_DIVIDE:  if (div_done || !div_busy) state_d = ST_MEASURE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A rise while dividing means the period was too short to trust; its result is discarded.
  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    timeout_d   = rise ? 1'b0 : timeout_q;
    stale_d     = stale_q;
    div_start   = 1'b0;
    case (state_q)
      ST_MEASURE: begin
        if (rise) begin
          period_d    = per_cnt_q;
          high_time_d = hi_cnt_q;
          div_start   = 1'b1;
          stale_d     = 1'b0;
        end else if (per_cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          duty_d    = {N_bits{s}};
          valid_d   = 1'b1;
        end
      end
      ST_DIVIDE: begin
        if (rise) stale_d = 1'b1;
        if (div_done && !(stale_q || rise)) begin
          duty_d  = div_quotient;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      s_dly_q     <= 1'b0;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stale_q     <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      sync_q      <= sync_d;
      s_dly_q     <= s_dly_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      stale_q     <= stale_d;
      state_q     <= state_d;
    end
  end

  duty_divider #(
    .N_bits  (N_bits),
    .CNT_BITS(CNT_BITS)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(hi_cnt_q),
    .divisor (per_cnt_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quotient)
  );

endmodule

// File: tb/tb_pwm_demodulator.sv
// tb/tb_pwm_demodulator.sv - directed bench for pwm_demodulator
module tb_pwm_demodulator;

  localparam int NB  = 8;
  localparam int CB  = 12;
  localparam int LAT = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [NB-1:0] duty;
  logic [CB-1:0] period, high_time;
  logic          valid, timeout;

  int passed = 0, total = 0;
  int cyc = 0, hi_start = 0, vcnt = 0, last_lat = 0;
  logic [NB-1:0] last_duty = '0;
  logic [CB-1:0] last_per = '0, last_hi = '0;

  pwm_demodulator #(.N_bits(NB), .CNT_BITS(CB), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input logic lvl);
    pwm_in = lvl;
    @(posedge clk);
    cyc++;
    #1;
    if (valid === 1'b1) begin
      vcnt++;
      last_duty = duty;
      last_per  = period;
      last_hi   = high_time;
      last_lat  = cyc - hi_start;
    end
  endtask

  task automatic pwm(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      hi_start = cyc + 1;
      for (int i = 0; i < p; i++) step(i < h);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl);
  endtask

  initial begin
    rst = 1'b1;
    hold(1'b0, 3);
    check("rst_duty", 32'(duty), 0);
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;

    vcnt = 0;
    pwm(256, 64, 4);
    check("p256h64_vcnt", vcnt, 3);
    check("p256h64_duty", 32'(last_duty), 32'h40);
    check("p256h64_period", 32'(last_per), 256);
    check("p256h64_high", 32'(last_hi), 64);
    check("p256h64_latency", last_lat, LAT);
    check("p256h64_valid_low", 32'(valid), 0);

    pwm(256, 1, 1);
    pwm(256, 255, 1);
    check("h1_duty", 32'(last_duty), 32'h01);
    check("h1_high", 32'(last_hi), 1);
    pwm(1000, 333, 1);
    check("h255_duty", 32'(last_duty), 32'hFF);
    check("h255_high", 32'(last_hi), 255);
    pwm(1000, 333, 1);
    check("p1000_duty", 32'(last_duty), 85);
    check("p1000_period", 32'(last_per), 1000);
    check("p1000_high", 32'(last_hi), 333);

    vcnt = 0;
    hold(1'b1, 4200);
    check("tmo_hi_vcnt", vcnt, 2);
    check("tmo_hi_flag", 32'(timeout), 1);
    check("tmo_hi_duty", 32'(last_duty), 32'hFF);
    check("tmo_hi_period_held", 32'(period), 1000);
    check("tmo_hi_high_held", 32'(high_time), 333);

    vcnt = 0;
    hold(1'b0, 3);
    pwm(256, 64, 2);
    check("resume_vcnt", vcnt, 1);
    check("resume_timeout", 32'(timeout), 0);
    check("resume_duty", 32'(last_duty), 32'h40);
    check("resume_latency", last_lat, LAT);

    vcnt = 0;
    hold(1'b0, 4200);
    check("tmo_lo_vcnt", vcnt, 1);
    check("tmo_lo_flag", 32'(timeout), 1);
    check("tmo_lo_duty", 32'(duty), 0);

    vcnt = 0;
    pwm(6, 3, 20);
    check("short_vcnt", vcnt, 0);
    check("short_timeout", 32'(timeout), 0);
    pwm(256, 64, 3);
    check("after_short_duty", 32'(last_duty), 32'h40);
    check("after_short_period", 32'(last_per), 256);
    check("after_short_latency", last_lat, LAT);

    vcnt = 0;
    hi_start = cyc + 1;
    hold(1'b1, 5);
    check("pre_rst_duty", 32'(duty), 32'h40);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("mid_rst_duty", 32'(duty), 0);
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_high", 32'(high_time), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_timeout", 32'(timeout), 0);
    hold(1'b0, 300);
    check("post_rst_no_valid", vcnt, 0);
    pwm(256, 64, 2);
    check("post_rst_vcnt", vcnt, 1);
    check("post_rst_duty", 32'(last_duty), 32'h40);
    check("post_rst_period", 32'(last_per), 256);
    check("post_rst_high", 32'(last_hi), 64);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
